// File: rtl/i2s_tx_multichannel.sv
// i2s_tx_multichannel: frame FIFO feeding an I2S (2 ch) / TDM (4/8 ch) playback serializer.
// Ports: board_clk, reset (async, active-high); enable runs the serial link;
//   s_frame/s_valid/s_ready frame write port, channel 0 in the MSBs; fifo_level frames stored;
//   underrun sticky flag, cleared by underrun_clr; ac_bclk/ac_pblrc/ac_pbdat serial outputs.
// Build option: SAMPLER_I2S_UNDERRUN_REPEAT_EN replays the last popped frame on underrun
//   instead of sending silence.
module i2s_tx_multichannel #(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int BCLK_DIV   = 4
) (
  input  logic                           board_clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_CH*SAMPLE_W-1:0]     s_frame,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           underrun,
  input  logic                           underrun_clr,
  output logic                           ac_bclk,
  output logic                           ac_pblrc,
  output logic                           ac_pbdat
);
  localparam int FW = NUM_CH * SAMPLE_W;
  localparam int FB = NUM_CH * SLOT_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(FB);
  localparam logic [DW-1:0] D_MAX  = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] D_HALF = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] F_MAX  = BW'(FB - 1);
  localparam logic [BW-1:0] F_SLOT = BW'(SLOT_W);
  localparam logic [AW:0]   FULL   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt, cnt_nxt;
  logic [DW-1:0] d, d_nxt;
  logic [BW-1:0] f, f_nxt;
  logic [FB-1:0] sr, sr_nxt, padded;
  logic [FW-1:0] load;
  logic push, pop, start, wrap, frame_end, hold;
  logic ur_nxt, bclk_nxt, lrc_nxt, dat_nxt;

  // ready depends only on the stored count, never on a same-cycle pop
  assign s_ready    = cnt != FULL;
  assign fifo_level = cnt;
  assign push       = s_valid && s_ready;

`ifdef SAMPLER_I2S_UNDERRUN_REPEAT_EN
  logic [FW-1:0] last;
  always_ff @(posedge board_clk or posedge reset)
    if (reset) last <= '0;
    else if (pop) last <= mem[rp];
  assign load = pop ? mem[rp] : last;
`else
  assign load = pop ? mem[rp] : '0;
`endif

  // each sample sits MSB-aligned in its slot, zero padded below
  for (genvar c = 0; c < NUM_CH; c++) begin : g_pad
    assign padded[FB-1-c*SLOT_W -: SLOT_W] =
      SLOT_W'(load[FW-1-c*SAMPLE_W -: SAMPLE_W]) << (SLOT_W - SAMPLE_W);
  end

  always_comb begin
    state_nxt = enable ? RUN : IDLE;
    hold      = !enable || state == IDLE;
    wrap      = state == RUN && d == D_MAX;
    frame_end = wrap && f == F_MAX;
    start     = enable && (state == IDLE || frame_end);
    pop       = start && cnt != '0;
    d_nxt     = hold || wrap ? '0 : d + 1'b1;
    f_nxt     = hold || frame_end ? '0 : f + BW'(wrap);
    sr_nxt    = !enable ? '0 : start ? padded : wrap ? sr << 1 : sr;
    // the delay flop takes the outgoing stream bit on the bclk falling edge
    dat_nxt   = hold ? 1'b0 : wrap ? sr[FB-1] : ac_pbdat;
    lrc_nxt   = !enable ? 1'b0 : (state == IDLE || wrap) ?
                (NUM_CH == 2 ? f_nxt >= F_SLOT : f_nxt == '0) : ac_pblrc;
    bclk_nxt  = d_nxt >= D_HALF;
    ur_nxt    = start && cnt == '0 ? 1'b1 : underrun_clr ? 1'b0 : underrun;
    cnt_nxt   = cnt + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge board_clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      d        <= '0;
      f        <= '0;
      sr       <= '0;
      underrun <= 1'b0;
      ac_bclk  <= 1'b0;
      ac_pblrc <= 1'b0;
      ac_pbdat <= 1'b0;
    end else begin
      state    <= state_nxt;
      wp       <= wp + AW'(push);
      rp       <= rp + AW'(pop);
      cnt      <= cnt_nxt;
      d        <= d_nxt;
      f        <= f_nxt;
      sr       <= sr_nxt;
      underrun <= ur_nxt;
      ac_bclk  <= bclk_nxt;
      ac_pblrc <= lrc_nxt;
      ac_pbdat <= dat_nxt;
    end

  always_ff @(posedge board_clk)
    if (push) mem[wp] <= s_frame;
endmodule

// File: tb/tb_i2s_tx_multichannel.sv
// tb_i2s_tx_multichannel: I2S and TDM instances checked against a frame-level stream model.
module tb_i2s_tx_multichannel;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;

  logic        a_en = 0, a_valid = 0, a_clr = 0, a_ready, a_ur, a_bclk, a_lrc, a_dat;
  logic [47:0] a_frame = '0;
  logic [2:0]  a_level;
  logic         t_en = 0, t_valid = 0, t_clr = 0, t_ready, t_ur, t_bclk, t_lrc, t_dat;
  logic [127:0] t_frame = '0;
  logic [4:0]   t_level;

  i2s_tx_multichannel #(.SAMPLE_W(24), .SLOT_W(32), .NUM_CH(2), .FIFO_DEPTH(4), .BCLK_DIV(4)) u_i2s (
    .board_clk(clk), .reset(reset), .enable(a_en), .s_frame(a_frame), .s_valid(a_valid),
    .s_ready(a_ready), .fifo_level(a_level), .underrun(a_ur), .underrun_clr(a_clr),
    .ac_bclk(a_bclk), .ac_pblrc(a_lrc), .ac_pbdat(a_dat));

  i2s_tx_multichannel #(.SAMPLE_W(16), .SLOT_W(16), .NUM_CH(8), .FIFO_DEPTH(16), .BCLK_DIV(2)) u_tdm (
    .board_clk(clk), .reset(reset), .enable(t_en), .s_frame(t_frame), .s_valid(t_valid),
    .s_ready(t_ready), .fifo_level(t_level), .underrun(t_ur), .underrun_clr(t_clr),
    .ac_bclk(t_bclk), .ac_pblrc(t_lrc), .ac_pbdat(t_dat));

`ifdef SAMPLER_I2S_UNDERRUN_REPEAT_EN
  localparam bit REP = 1;
`else
  localparam bit REP = 0;
`endif

  int checks = 0, errors = 0;
  logic [127:0] q0[$], q1[$];
  logic [127:0] prev[2], cur[2], last[2];
  bit urx[2];

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  function automatic int qsize(input int sel);
    return sel ? q1.size() : q0.size();
  endfunction
  function automatic logic [127:0] qpop(input int sel);
    if (sel) return q1.pop_front();
    return q0.pop_front();
  endfunction
  function automatic logic o_bclk(input int sel); return sel ? t_bclk : a_bclk; endfunction
  function automatic logic o_lrc(input int sel);  return sel ? t_lrc  : a_lrc;  endfunction
  function automatic logic o_dat(input int sel);  return sel ? t_dat  : a_dat;  endfunction
  function automatic logic o_ur(input int sel);   return sel ? t_ur   : a_ur;   endfunction
  function automatic logic o_rdy(input int sel);  return sel ? t_ready : a_ready; endfunction
  function automatic int o_lvl(input int sel);    return sel ? int'(t_level) : int'(a_level); endfunction

  task automatic set_en(input int sel, input logic v);
    if (sel) t_en = v;
    else a_en = v;
  endtask

  task automatic push(input int sel, input logic [127:0] fr);
    @(negedge clk);
    if (sel) begin t_frame = fr; t_valid = 1; q1.push_back(fr); end
    else begin a_frame = fr[47:0]; a_valid = 1; q0.push_back(128'(fr[47:0])); end
    @(negedge clk);
    a_valid = 0;
    t_valid = 0;
  endtask

  // Enables the link and checks nb bclks against the stream model: each frame is
  // slot 0..N-1 of sample bits MSB-first plus zero padding, emitted one bclk late.
  task automatic run_frames(input int sel, input int nb);
    int nch, slot, samp, div, dep, fb, p, s, b;
    logic [127:0] fr;
    logic ed, el;
    nch = sel ? 8 : 2; slot = sel ? 16 : 32; samp = sel ? 16 : 24;
    div = sel ? 2 : 4; dep = sel ? 16 : 4; fb = nch * slot;
    @(negedge clk);
    set_en(sel, 1);
    for (int k = 0; k < nb; k++) begin
      if (k % fb == 0) begin
        prev[sel] = cur[sel];
        if (qsize(sel) > 0) begin cur[sel] = qpop(sel); last[sel] = cur[sel]; end
        else begin cur[sel] = REP ? last[sel] : '0; urx[sel] = 1; end
      end
      @(negedge clk);
      checks++;
      if (o_bclk(sel) !== 1'b0) begin errors++; $display("FAIL bclk_low sel=%0d k=%0d got=%b exp=0", sel, k, o_bclk(sel)); end
      checks++;
      if (o_lvl(sel) !== qsize(sel) || o_rdy(sel) !== (qsize(sel) < dep)) begin
        errors++; $display("FAIL level sel=%0d k=%0d got=%0d/%b exp=%0d/%b", sel, k, o_lvl(sel), o_rdy(sel), qsize(sel), qsize(sel) < dep);
      end
      repeat (div / 2) @(negedge clk);
      ed = 1'b0;
      if (k > 0) begin
        p = (k - 1) % fb;
        fr = (k % fb == 0) ? prev[sel] : cur[sel];
        s = p / slot; b = p % slot;
        ed = b < samp ? fr[(nch - s) * samp - 1 - b] : 1'b0;
      end
      el = nch == 2 ? (k % fb >= slot) : (k % fb == 0);
      checks++;
      if (o_bclk(sel) !== 1'b1) begin errors++; $display("FAIL bclk_high sel=%0d k=%0d got=%b exp=1", sel, k, o_bclk(sel)); end
      checks++;
      if (o_dat(sel) !== ed) begin errors++; $display("FAIL pbdat sel=%0d k=%0d got=%b exp=%b", sel, k, o_dat(sel), ed); end
      checks++;
      if (o_lrc(sel) !== el) begin errors++; $display("FAIL pblrc sel=%0d k=%0d got=%b exp=%b", sel, k, o_lrc(sel), el); end
      checks++;
      if (o_ur(sel) !== urx[sel]) begin errors++; $display("FAIL underrun sel=%0d k=%0d got=%b exp=%b", sel, k, o_ur(sel), urx[sel]); end
      repeat (div / 2 - 1) @(negedge clk);
    end
  endtask

  task automatic stop_and_clear(input int sel);
    set_en(sel, 0);
    @(negedge clk);
    checks++;
    if ({o_bclk(sel), o_lrc(sel), o_dat(sel)} !== 3'b000 || o_lvl(sel) !== qsize(sel)) begin
      errors++; $display("FAIL disable sel=%0d got=%b%b%b lvl=%0d exp=000 lvl=%0d", sel, o_bclk(sel), o_lrc(sel), o_dat(sel), o_lvl(sel), qsize(sel));
    end
    if (sel) t_clr = 1; else a_clr = 1;
    @(negedge clk);
    t_clr = 0; a_clr = 0; urx[sel] = 0;
    checks++;
    if (o_ur(sel) !== 1'b0) begin errors++; $display("FAIL underrun_clr sel=%0d got=%b exp=0", sel, o_ur(sel)); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++;
    if ({a_bclk, a_lrc, a_dat, a_ur, a_ready, a_level} !== 8'b0000_1_000) begin
      errors++; $display("FAIL reset_i2s got=%b exp=00001000", {a_bclk, a_lrc, a_dat, a_ur, a_ready, a_level});
    end
    checks++;
    if ({t_bclk, t_lrc, t_dat, t_ur, t_ready, t_level} !== 10'b0000_1_00000) begin
      errors++; $display("FAIL reset_tdm got=%b exp=0000100000", {t_bclk, t_lrc, t_dat, t_ur, t_ready, t_level});
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] fr;
    @(negedge clk);
    a_valid = 1;
    for (int i = 0; i < 6; i++) begin
      fr = (i == 0) ? 128'({24'hABCDEF, 24'h123456}) : rnd();
      a_frame = fr[47:0];
      if (i < 4) q0.push_back(128'(fr[47:0]));
      @(negedge clk);
    end
    a_valid = 0;
    checks++;
    if (a_level !== 3'd4) begin errors++; $display("FAIL bp_level got=%0d exp=4", a_level); end
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", a_ready); end
  endtask

  task automatic test_stereo();
    run_frames(0, 5 * 64);
    stop_and_clear(0);
  endtask

  task automatic test_underrun();
    push(0, rnd());
    run_frames(0, 2 * 64 + 4);
    stop_and_clear(0);
  endtask

  task automatic test_disable();
    push(0, rnd());
    push(0, rnd());
    run_frames(0, 11);
    stop_and_clear(0);
    run_frames(0, 64 + 3);
    stop_and_clear(0);
  endtask

  task automatic test_tdm();
    logic [127:0] fr;
    for (int n = 0; n < 8; n++) fr[(8 - n) * 16 - 1 -: 16] = 16'(16'h1111 * n);
    push(1, fr);
    push(1, rnd());
    run_frames(1, 2 * 128 + 3);
    stop_and_clear(1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push(0, rnd());
    push(1, rnd());
    run_frames(0, 20);
    reset = 1;
    @(negedge clk);
    checks++;
    if ({a_bclk, a_lrc, a_dat, a_ur, a_ready, a_level} !== 8'b0000_1_000) begin
      errors++; $display("FAIL reset_mid_i2s got=%b exp=00001000", {a_bclk, a_lrc, a_dat, a_ur, a_ready, a_level});
    end
    checks++;
    if ({t_ready, t_level} !== 6'b1_00000) begin errors++; $display("FAIL reset_mid_tdm got=%b exp=100000", {t_ready, t_level}); end
    a_en = 0;
    q0.delete(); q1.delete();
    last[0] = '0; last[1] = '0; urx[0] = 0; urx[1] = 0;
    @(negedge clk);
    reset = 0;
    push(0, rnd());
    run_frames(0, 64 + 2);
    stop_and_clear(0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin prev[i] = '0; cur[i] = '0; last[i] = '0; urx[i] = 0; end
    test_reset();
    test_backpressure();
    test_stereo();
    test_underrun();
    test_disable();
    test_tdm();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/i2s_tx_multichannel.md
# i2s_tx_multichannel

Parametrised playback serializer for the codec unit: buffers complete audio frames in an internal FIFO and shifts them out as I2S (2 channels) or TDM (4/8 channels) on `ac_bclk`/`ac_pblrc`/`ac_pbdat`, deriving the bit clock from `board_clk`. It generalises the fixed stereo 24-bit playback path to configurable sample width, slot width, channel count and buffer depth. It adds underrun detection and a frame-level valid/ready write port fed by the sampler engine.

## Interface
- `SAMPLE_W`, 24: bits per sample, MSB-first; must be ≤ `SLOT_W`.
- `SLOT_W`, 32: bclk periods per channel slot; the bits after the sample are driven 0.
- `NUM_CH`, 2: channels per frame, one of 2, 4 or 8. 2 selects I2S; 4 and 8 select TDM.
- `FIFO_DEPTH`, 16: frames buffered; must be a power of 2, ≥2.
- `BCLK_DIV`, 4: `board_clk` cycles per bclk period; must be even, ≥2.
- `board_clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  runs the serial interface.
- `s_frame`  in  NUM_CH*SAMPLE_W  one frame; channel 0 in the MSBs.
- `s_valid`  in  1  `s_frame` is valid.
- `s_ready`  out  1  FIFO can accept a frame; equals !full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  frames currently stored.
- `underrun`  out  1  sticky; set when a frame is due and the FIFO is empty.
- `underrun_clr`  in  1  clears `underrun`.
- `ac_bclk`, `ac_pblrc`, `ac_pbdat`  out  1 each  serial outputs.

## Operation
- **Write port.**
  - A frame is written on any cycle with `s_valid && s_ready`.
  - Writes are accepted regardless of `enable`.
- **Simultaneous push and pop.**
  - `fifo_level` is unchanged.
  - When full, the pop frees the slot and `s_ready` rises on the next cycle. Ready is never combinationally dependent on the pop.
- **States.**
  - IDLE: `enable`=0. `ac_bclk`, `ac_pblrc` and `ac_pbdat` are held 0, and all counters are held 0.
  - RUN: `enable`=1.
  - Deasserting `enable` in RUN returns to IDLE on the next cycle and discards the frame in flight; the FIFO contents are kept.
- **Counters.**
  - Divider `d` counts 0..BCLK_DIV-1; `ac_bclk` = (d ≥ BCLK_DIV/2).
  - Frame bit counter `f` counts 0..NUM_CH*SLOT_W-1 and advances when `d` wraps, i.e. on the bclk falling edge.
- **Frame start.** A frame starts on the IDLE→RUN cycle and on every wrap of `f` to 0.
  - If the FIFO is non-empty, pop one frame into the shift register.
  - If it is empty, set `underrun` (only in RUN) and load an all-zero frame.
- **Serial stream.** The stream is slot 0..NUM_CH-1. Each slot is `SAMPLE_W` sample bits MSB-first, then `SLOT_W-SAMPLE_W` zeros.
  - `ac_pbdat` carries this stream delayed by one bclk through a delay flop, which gives the I2S one-bit delay.
  - The first bit after leaving IDLE is 0.
- **Frame clock `ac_pblrc`.**
  - I2S (`NUM_CH`=2): 0 for f < SLOT_W, else 1.
  - TDM: 1 for f = 0 only, else 0.
- **Underrun flag.** Set has priority over `underrun_clr` in the same cycle.

## Timing
- **Reset values.**
  - `ac_bclk`, `ac_pblrc`, `ac_pbdat`, `underrun` and `fifo_level`: 0.
  - `s_ready`: 1.
  - State: IDLE.
- **Edge alignment.**
  - All serial outputs are registered and change only when `d` is 0, which is the bclk falling edge.
  - `ac_bclk` rises BCLK_DIV/2 cycles after entering RUN.
- **Pop timing.** The pop occurs in the same cycle that `f` becomes 0. `fifo_level` decrements on the following cycle.
- **Latency, FIFO empty when enabled.** The first valid MSB reaches `ac_pbdat` at bclk 1 of the frame after the frame the data was written behind.
- **Latency, frame written before `enable`.** Its channel-0 MSB appears at `board_clk` cycle BCLK_DIV after the IDLE→RUN cycle.
- **Frame period.** NUM_CH*SLOT_W*BCLK_DIV `board_clk` cycles.
- **Reset mid-operation.** Immediately returns all state and outputs to the reset values and empties the FIFO.

## Configuration
- Macro `SAMPLER_I2S_UNDERRUN_REPEAT_EN`.
- When defined: on underrun, the last successfully popped frame is reloaded and replayed. Before the first pop after reset, zeros are loaded.
- When undefined: on underrun, the all-zero frame is loaded.
- `underrun` sets identically in both builds.

## Test plan
- **Reset.** Assert `reset` mid-frame with a full FIFO → next cycle all serial outputs are 0, `fifo_level`=0 and `s_ready`=1.
- **Stereo I2S.** Default parameters; write 24'hABCDEF / 24'h123456, then enable.
  - `ac_pbdat` shows 0, then 24'hABCDEF MSB-first, then 7 zeros while `ac_pblrc`=0.
  - One bclk after `ac_pblrc` rises, 24'h123456 follows.
  - Frame period is 256 `board_clk` cycles.
- **TDM.** NUM_CH=8, SLOT_W=16, SAMPLE_W=16, channel n = 16'h1111*n.
  - `ac_pblrc` pulses for one bclk every 128 bclks.
  - Slot n carries 16'h1111*n, starting one bclk after the pulse.
- **Backpressure.** FIFO_DEPTH=4; hold `s_valid`=1 with enable=0.
  - Exactly 4 frames are accepted; `s_ready` is 0 and `fifo_level`=4.
  - After enabling, `s_ready` rises the cycle after the first pop.
- **Underrun.** Run with one frame written.
  - `underrun` sets at the second frame start.
  - Output is zeros, or the repeated frame with `SAMPLER_I2S_UNDERRUN_REPEAT_EN`.
  - Pulsing `underrun_clr` with no new underrun clears the flag.
- **Disable mid-frame.** Drop `enable` at f=10 → outputs are 0 the next cycle. On re-enable, a new frame starts with f=0 and pops the next FIFO entry.
